// File: rtl/input_conditioner_if.sv
// input_conditioner_if: raw input, counter clear and conditioned outputs of the input conditioner.
interface input_conditioner_if #(
  parameter int CNT_W = 8
);
  logic             d_raw;
  logic             cnt_clr;
  logic             d_clean;
  logic             d_clean_bar;
  logic             rise;
  logic             fall;
  logic             busy;
  logic [CNT_W-1:0] evt_cnt;
  modport master (
    output d_raw, cnt_clr,
    input  d_clean, d_clean_bar, rise, fall, busy, evt_cnt
  );
  modport slave (
    input  d_raw, cnt_clr,
    output d_clean, d_clean_bar, rise, fall, busy, evt_cnt
  );
endinterface

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes, debounces and edge-detects a raw 1-bit input.
// Define INPUT_CONDITIONER_SAT_EN to make evt_cnt saturate instead of wrapping.
module input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input logic                 clk,
  input logic                 rst,
  input_conditioner_if.slave  bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_t;
  state_t           state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]    cnt, cnt_n;
  logic             s;
  logic             last;
  logic             commit_hi, commit_lo;
  logic             d_clean, rise, fall;
  logic [CNT_W-1:0] evt, evt_inc, evt_n;
  assign s    = sync[SYNC_STAGES-1];
  assign last = cnt == CW'(DEBOUNCE_CYCLES - 1);
`ifdef INPUT_CONDITIONER_SAT_EN
  assign evt_inc = &evt ? evt : evt + CNT_W'(1);
`else
  assign evt_inc = evt + CNT_W'(1);
`endif
  // a clear coinciding with a rising commit still records that event
  assign evt_n = bus.cnt_clr ? CNT_W'(commit_hi) : commit_hi ? evt_inc : evt;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= '0;
      state   <= STABLE_LO;
      cnt     <= '0;
      d_clean <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      evt     <= '0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], bus.d_raw};
      state   <= state_n;
      cnt     <= cnt_n;
      d_clean <= commit_hi ? 1'b1 : commit_lo ? 1'b0 : d_clean;
      rise    <= commit_hi;
      fall    <= commit_lo;
      evt     <= evt_n;
    end
  end
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    commit_hi = 1'b0;
    commit_lo = 1'b0;
    unique case (state)
      STABLE_LO: if (s) begin
        if (DEBOUNCE_CYCLES == 1) begin
          commit_hi = 1'b1;
          state_n   = STABLE_HI;
        end else begin
          state_n = WAIT_HI;
          cnt_n   = CW'(1);
        end
      end
      WAIT_HI: if (!s) begin
        state_n = STABLE_LO;
        cnt_n   = '0;
      end else if (last) begin
        commit_hi = 1'b1;
        state_n   = STABLE_HI;
        cnt_n     = '0;
      end else cnt_n = cnt + CW'(1);
      STABLE_HI: if (!s) begin
        if (DEBOUNCE_CYCLES == 1) begin
          commit_lo = 1'b1;
          state_n   = STABLE_LO;
        end else begin
          state_n = WAIT_LO;
          cnt_n   = CW'(1);
        end
      end
      WAIT_LO: if (s) begin
        state_n = STABLE_HI;
        cnt_n   = '0;
      end else if (last) begin
        commit_lo = 1'b1;
        state_n   = STABLE_LO;
        cnt_n     = '0;
      end else cnt_n = cnt + CW'(1);
      default: begin
        state_n = STABLE_LO;
        cnt_n   = '0;
      end
    endcase
  end
  always_comb begin
    bus.d_clean     = d_clean;
    bus.d_clean_bar = ~d_clean;
    bus.rise        = rise;
    bus.fall        = fall;
    bus.busy        = state == WAIT_HI || state == WAIT_LO;
    bus.evt_cnt     = evt;
  end
endmodule
